// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader: FSM encoding, default sync marker,
// and frame-field byte offsets.
package uart_boot_loader_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLenLo = 3'd1,
    StLenHi = 3'd2,
    StData  = 3'd3,
    StChk   = 3'd4,
    StDone  = 3'd5
  } state_e;

  localparam logic [7:0] DefaultSyncByte = 8'hA5;

  localparam int unsigned FrameOffsSync  = 0;
  localparam int unsigned FrameOffsLenLo = 1;
  localparam int unsigned FrameOffsLenHi = 2;
  localparam int unsigned FrameOffsData  = 3;

endpackage

// File: rtl/uart_boot_loader_rx_edge_detect.sv
// Registered rising-edge detector on rx_ready: one byte_valid per byte, however long
// the receiver holds its ready level.
module rx_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rx_ready,
  output logic o_byte_valid
);

  logic r_rx_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_ready <= 1'b0;
    end else begin
      r_rx_ready <= i_rx_ready;
    end
  end

  assign o_byte_valid = i_rx_ready & ~r_rx_ready;

endmodule

// File: rtl/uart_boot_loader.sv
// Boot loader FSM: frames UART bytes into little-endian 32-bit words written to instruction
// memory. Define UART_BOOT_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [7:0]  SYNC_BYTE = DefaultSyncByte
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_load_done,
  output logic              o_load_err
);

  localparam int unsigned Cap = 32'd1 << ADDR_W;

  state_e              r_state, w_state_d;
  logic [15:0]         r_len, w_len_d;
  logic [ADDR_W-1:0]   r_addr, w_addr_d;
  logic [1:0]          r_idx, w_idx_d;
  logic [23:0]         r_word, w_word_d;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_d;
  logic [31:0]         r_mem_wdata, w_mem_wdata_d;
  logic                r_mem_we, w_mem_we_d;
  logic                r_hold, w_hold_d;
  logic                r_done, w_done_d;
  logic                r_err, w_err_d;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
  logic [7:0]          r_xor, w_xor_d;
`endif

  logic        w_byte_valid;
  logic [15:0] w_len_in;
  logic        w_last_word;
  logic        w_finish;
  logic        w_fail;

  rx_edge_detect u_rx_edge (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rx_ready   (i_rx_ready),
    .o_byte_valid (w_byte_valid)
  );

  assign w_len_in    = {i_rx_data, r_len[7:0]};
  assign w_last_word = (32'(r_addr) == 32'(r_len) - 32'd1);

  always_comb begin
    w_state_d     = r_state;
    w_len_d       = r_len;
    w_addr_d      = r_addr;
    w_idx_d       = r_idx;
    w_word_d      = r_word;
    w_mem_addr_d  = r_mem_addr;
    w_mem_wdata_d = r_mem_wdata;
    w_mem_we_d    = 1'b0;
    w_hold_d      = r_hold;
    w_done_d      = 1'b0;
    w_err_d       = r_err;
    w_finish      = 1'b0;
    w_fail        = 1'b0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    w_xor_d       = r_xor;
`endif

    unique case (r_state)
      StIdle: begin
        if (w_byte_valid && (i_rx_data == SYNC_BYTE)) begin
          w_state_d = StLenLo;
          w_hold_d  = 1'b1;
          w_err_d   = 1'b0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
          w_xor_d   = 8'h00;
`endif
        end
      end
      StLenLo: begin
        if (w_byte_valid) begin
          w_len_d[7:0] = i_rx_data;
          w_state_d    = StLenHi;
        end
      end
      StLenHi: begin
        if (w_byte_valid) begin
          w_len_d[15:8] = i_rx_data;
          if (32'(w_len_in) > Cap) begin
            w_fail = 1'b1;
          end else if (w_len_in == 16'd0) begin
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            w_state_d = StChk;
`else
            w_finish  = 1'b1;
`endif
          end else begin
            w_state_d = StData;
            w_addr_d  = '0;
            w_idx_d   = 2'd0;
          end
        end
      end
      StData: begin
        if (w_byte_valid) begin
          w_idx_d = r_idx + 2'd1;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
          w_xor_d = r_xor ^ i_rx_data;
`endif
          unique case (r_idx)
            2'd0: w_word_d[7:0]   = i_rx_data;
            2'd1: w_word_d[15:8]  = i_rx_data;
            2'd2: w_word_d[23:16] = i_rx_data;
            2'd3: begin
              w_mem_we_d    = 1'b1;
              w_mem_addr_d  = r_addr;
              w_mem_wdata_d = {i_rx_data, r_word};
              w_addr_d      = r_addr + ADDR_W'(1);
              if (w_last_word) begin
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
                w_state_d = StChk;
`else
                w_finish  = 1'b1;
`endif
              end
            end
            default: ;
          endcase
        end
      end
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
      StChk: begin
        if (w_byte_valid) begin
          if (i_rx_data == r_xor) begin
            w_finish = 1'b1;
          end else begin
            w_fail = 1'b1;
          end
        end
      end
`endif
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

    if (w_finish) begin
      w_state_d = StDone;
      w_done_d  = 1'b1;
      w_hold_d  = 1'b0;
    end
    if (w_fail) begin
      w_state_d = StIdle;
      w_err_d   = 1'b1;
      w_hold_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_len       <= '0;
      r_addr      <= '0;
      r_idx       <= '0;
      r_word      <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_hold      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
      r_xor       <= '0;
`endif
    end else begin
      r_state     <= w_state_d;
      r_len       <= w_len_d;
      r_addr      <= w_addr_d;
      r_idx       <= w_idx_d;
      r_word      <= w_word_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
      r_mem_we    <= w_mem_we_d;
      r_hold      <= w_hold_d;
      r_done      <= w_done_d;
      r_err       <= w_err_d;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
      r_xor       <= w_xor_d;
`endif
    end
  end

  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_cpu_hold  = r_hold;
  assign o_load_done = r_done;
  assign o_load_err  = r_err;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: directed frame table, hand-timed corner sequences and random
// byte streams checked against a frame-level parser model. Two DUTs: ADDR_W=10 and ADDR_W=2.
module tb_uart_boot_loader;

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif
  localparam logic [7:0] SyncByte = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;

  logic        b_we, b_hold, b_done, b_err;
  logic [9:0]  b_addr;
  logic [31:0] b_wdata;
  logic        s_we, s_hold, s_done, s_err;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  stim[$];
  logic [63:0] act_q[2][$];
  int          act_done[2];
  logic [63:0] exp_q[2][$];
  int          exp_done[2];
  bit          exp_err[2];
  bit          exp_hold[2];

  always #5 clk = ~clk;

  uart_boot_loader #(.ADDR_W(10)) u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_ready  (rx_ready),
    .o_mem_we    (b_we),
    .o_mem_addr  (b_addr),
    .o_mem_wdata (b_wdata),
    .o_cpu_hold  (b_hold),
    .o_load_done (b_done),
    .o_load_err  (b_err)
  );

  uart_boot_loader #(.ADDR_W(2)) u_dut_small (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_ready  (rx_ready),
    .o_mem_we    (s_we),
    .o_mem_addr  (s_addr),
    .o_mem_wdata (s_wdata),
    .o_cpu_hold  (s_hold),
    .o_load_done (s_done),
    .o_load_err  (s_err)
  );

  // Every high cycle of mem_we is one write record, so a stretched strobe shows up as extra.
  always @(negedge clk) begin
    if (!rst_n) begin
      act_q[0].delete();
      act_q[1].delete();
      act_done[0] = 0;
      act_done[1] = 0;
    end else begin
      if (b_we) act_q[0].push_back({32'(b_addr), b_wdata});
      if (s_we) act_q[1].push_back({32'(s_addr), s_wdata});
      if (b_done) act_done[0]++;
      if (s_done) act_done[1]++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rx_ready = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stim.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    repeat (hold) @(negedge clk);
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    stim.push_back(b);
  endtask

  // Frame-level parser over the whole byte history since reset.
  task automatic run_model(input int which, input int cap);
    int i;
    int n;
    int nw;
    logic [7:0] x;
    logic [31:0] w;
    bit partial;
    exp_q[which].delete();
    exp_done[which] = 0;
    exp_err[which]  = 1'b0;
    exp_hold[which] = 1'b0;
    n = stim.size();
    i = 0;
    while (i < n) begin
      if (stim[i] != SyncByte) begin
        i++;
        continue;
      end
      exp_err[which]  = 1'b0;
      exp_hold[which] = 1'b1;
      if (i + 3 > n) break;
      nw = int'(stim[i+1]) + 256 * int'(stim[i+2]);
      i += 3;
      if (nw > cap) begin
        exp_err[which]  = 1'b1;
        exp_hold[which] = 1'b0;
        continue;
      end
      x = 8'h00;
      partial = 1'b0;
      for (int k = 0; k < nw; k++) begin
        if (i + 4 > n) begin
          partial = 1'b1;
          break;
        end
        w = {stim[i+3], stim[i+2], stim[i+1], stim[i]};
        x = x ^ stim[i] ^ stim[i+1] ^ stim[i+2] ^ stim[i+3];
        exp_q[which].push_back({32'(k), w});
        i += 4;
      end
      if (partial) break;
      if (ChkEn) begin
        if (i >= n) break;
        if (stim[i] == x) exp_done[which]++;
        else exp_err[which] = 1'b1;
        i++;
      end else begin
        exp_done[which]++;
      end
      exp_hold[which] = 1'b0;
    end
  endtask

  task automatic compare_model(input int which, input int cap, input string tag);
    run_model(which, cap);
    check({tag, "_nwr"}, 64'(act_q[which].size()), 64'(exp_q[which].size()));
    for (int k = 0; k < exp_q[which].size() && k < act_q[which].size(); k++)
      check($sformatf("%s_wr%0d", tag, k), act_q[which][k], exp_q[which][k]);
    check({tag, "_done"}, 64'(act_done[which]), 64'(exp_done[which]));
    check({tag, "_err"}, 64'(which == 0 ? b_err : s_err), 64'(exp_err[which]));
    check({tag, "_hold"}, 64'(which == 0 ? b_hold : s_hold), 64'(exp_hold[which]));
  endtask

  typedef struct {
    logic [95:0] bytes;   // left-aligned, first byte in [95:88]
    int          nb;
    int          hold;
    bit          has_chk;
    logic [7:0]  chk;
    bit          bad_chk;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    int          done;
    bit          err;
    bit          hold_o;
  } vec_t;

  vec_t vt[7];

  task automatic set_vec(input int i, input logic [95:0] bytes, input int nb, input int hold,
                         input bit has_chk, input logic [7:0] chk, input bit bad_chk,
                         input int nw, input logic [31:0] w0, input logic [31:0] w1,
                         input int done, input bit err, input bit hold_o);
    vt[i].bytes = bytes;  vt[i].nb = nb;      vt[i].hold = hold;
    vt[i].has_chk = has_chk; vt[i].chk = chk; vt[i].bad_chk = bad_chk;
    vt[i].nw = nw;        vt[i].w0 = w0;      vt[i].w1 = w1;
    vt[i].done = done;    vt[i].err = err;    vt[i].hold_o = hold_o;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1);
  end

  initial begin
    int e_done;
    bit e_err;
    bit e_hold;
    logic [7:0] q[$];
    logic [7:0] x;
    logic [7:0] b;
    int nw;

    set_vec(0, {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 40'h0}, 7, 5, 1, 8'h08, 0,
            1, 32'h12345678, 32'h0, 1, 0, 0);
    set_vec(1, {8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                8'h0}, 11, 1, 1, 8'h08, 0, 2, 32'h04030201, 32'h08070605, 1, 0, 0);
    set_vec(2, {8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 16'h0},
            10, 1, 1, 8'h08, 0, 1, 32'h12345678, 32'h0, 1, 0, 0);
    set_vec(3, {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 40'h0}, 7, 1, 1, 8'h00, 1,
            1, 32'h12345678, 32'h0, 1, 0, 0);
    set_vec(4, {8'hA5, 8'h00, 8'h00, 72'h0}, 3, 1, 1, 8'h00, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    set_vec(5, {8'hA5, 8'h05, 8'h00, 72'h0}, 3, 1, 0, 8'h00, 0, 0, 32'h0, 32'h0, 0, 0, 1);
    set_vec(6, {8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 40'h0}, 7, 2, 1, 8'h00, 0,
            1, 32'hA5A5A5A5, 32'h0, 1, 0, 0);

    #2;
    check("rst_we", 64'(b_we), 64'(0));
    check("rst_addr", 64'(b_addr), 64'(0));
    check("rst_wdata", 64'(b_wdata), 64'(0));
    check("rst_hold", 64'(b_hold), 64'(0));
    check("rst_done", 64'(b_done), 64'(0));
    check("rst_err", 64'(b_err), 64'(0));

    for (int i = 0; i < 7; i++) begin
      do_reset();
      for (int j = 0; j < vt[i].nb; j++) send_byte(vt[i].bytes[95-8*j -: 8], vt[i].hold);
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
      if (vt[i].has_chk) send_byte(vt[i].chk, vt[i].hold);
`endif
      repeat (2) @(negedge clk);
      e_done = (ChkEn && vt[i].bad_chk) ? 0 : vt[i].done;
      e_err  = (ChkEn && vt[i].bad_chk) ? 1'b1 : vt[i].err;
      e_hold = (ChkEn && vt[i].bad_chk) ? 1'b0 : vt[i].hold_o;
      check($sformatf("v%0d_nwr", i), 64'(act_q[0].size()), 64'(vt[i].nw));
      if (vt[i].nw >= 1) check($sformatf("v%0d_w0", i), act_q[0][0], {32'd0, vt[i].w0});
      if (vt[i].nw >= 2) check($sformatf("v%0d_w1", i), act_q[0][1], {32'd1, vt[i].w1});
      check($sformatf("v%0d_done", i), 64'(act_done[0]), 64'(e_done));
      check($sformatf("v%0d_err", i), 64'(b_err), 64'(e_err));
      check($sformatf("v%0d_hold", i), 64'(b_hold), 64'(e_hold));
      compare_model(1, 4, $sformatf("v%0d_small", i));
      if (i == 5) begin
        check("oversize_small_err", 64'(s_err), 64'(1));
        check("oversize_small_nwr", 64'(act_q[1].size()), 64'(0));
      end
      if (vt[i].bad_chk) begin
        send_byte(SyncByte, 1);
        check("resync_err_clear", 64'(b_err), 64'(0));
        check("resync_hold", 64'(b_hold), 64'(1));
      end
    end

    // cpu_hold, mem_we and load_done cycle timing
    do_reset();
    @(negedge clk);
    rx_data = SyncByte;
    rx_ready = 1'b1;
    check("hold_before_sync", 64'(b_hold), 64'(0));
    @(negedge clk);
    check("hold_after_sync", 64'(b_hold), 64'(1));
    rx_ready = 1'b0;
    send_byte(8'h01, 1);
    send_byte(8'h00, 1);
    send_byte(8'h78, 1);
    send_byte(8'h56, 1);
    send_byte(8'h34, 1);
    @(negedge clk);
    rx_data = 8'h12;
    rx_ready = 1'b1;
    @(negedge clk);
    check("t_we_high", 64'(b_we), 64'(1));
    check("t_we_addr", 64'(b_addr), 64'(0));
    check("t_we_data", 64'(b_wdata), 64'(32'h12345678));
`ifndef UART_BOOT_LOADER_CHECKSUM_EN
    check("t_done_high", 64'(b_done), 64'(1));
    check("t_done_hold", 64'(b_hold), 64'(0));
`endif
    rx_ready = 1'b0;
    @(negedge clk);
    check("t_we_low", 64'(b_we), 64'(0));
    check("t_wdata_held", 64'(b_wdata), 64'(32'h12345678));
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    rx_data = 8'h08;
    rx_ready = 1'b1;
    @(negedge clk);
    check("t_done_high", 64'(b_done), 64'(1));
    check("t_done_hold", 64'(b_hold), 64'(0));
    rx_ready = 1'b0;
    @(negedge clk);
`endif
    check("t_done_low", 64'(b_done), 64'(0));

    // asynchronous reset mid-frame, then a fresh frame loads from address 0
    do_reset();
    for (int j = 0; j < 11; j++) send_byte(vt[1].bytes[95-8*j -: 8], 1);
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    send_byte(8'h08, 1);
`endif
    send_byte(SyncByte, 1);
    send_byte(8'h01, 1);
    send_byte(8'h00, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    check("mid_hold", 64'(b_hold), 64'(1));
    check("mid_addr", 64'(b_addr), 64'(1));
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_we", 64'(b_we), 64'(0));
    check("arst_addr", 64'(b_addr), 64'(0));
    check("arst_wdata", 64'(b_wdata), 64'(0));
    check("arst_hold", 64'(b_hold), 64'(0));
    check("arst_done", 64'(b_done), 64'(0));
    check("arst_err", 64'(b_err), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stim.delete();
    for (int j = 0; j < 7; j++) send_byte(vt[0].bytes[95-8*j -: 8], 1);
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    send_byte(8'h08, 1);
`endif
    repeat (2) @(negedge clk);
    compare_model(0, 1024, "post_rst");
    check("post_rst_w0", act_q[0][0], {32'd0, 32'h12345678});

    // random streams: garbage, short frames, stray sync values inside data, bad checksums
    for (int it = 0; it < 25; it++) begin
      do_reset();
      q.delete();
      for (int f = 0; f < 3; f++) begin
        repeat ($urandom_range(0, 2)) begin
          b = 8'($urandom);
          q.push_back(b == SyncByte ? 8'h00 : b);
        end
        nw = $urandom_range(0, 6);
        q.push_back(SyncByte);
        q.push_back(8'(nw));
        q.push_back(8'h00);
        x = 8'h00;
        for (int k = 0; k < 4 * nw; k++) begin
          b = ($urandom_range(0, 3) == 0) ? SyncByte : 8'($urandom);
          x = x ^ b;
          q.push_back(b);
        end
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        q.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : x);
`endif
      end
      foreach (q[k]) send_byte(q[k], $urandom_range(1, 3));
      repeat (3) @(negedge clk);
      compare_model(0, 1024, $sformatf("r%0d_big", it));
      compare_model(1, 4, $sformatf("r%0d_small", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
